// File: rtl/mmu_data_port.sv
// Data-side MMU port: latches one load/store, translates it through an 8-entry
// paired-page TLB (or the unmapped window), then runs a single bus access.
module mmu_data_port #(
  parameter int          TLB_INDEX_WIDTH = 3,
  parameter logic [4:0]  EC_NONE         = 5'h1F
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   req_opt,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  input  logic [TLB_INDEX_WIDTH+63:0]  tlb_write_struct,
  output logic [31:0]                  resp_rdata,
  output logic [4:0]                   resp_exc_code,
  output logic                         busy,
  output logic [31:0]                  phy_addr,
  output logic [31:0]                  phy_wdata,
  output logic [3:0]                   phy_be,
  output logic                         phy_rd,
  output logic                         phy_wr,
  input  logic [31:0]                  phy_rdata,
  input  logic                         phy_ack
);
  localparam int TLB_N = 1 << TLB_INDEX_WIDTH;

  localparam logic [2:0] OP_LW = 3'd1, OP_SW = 3'd2, OP_LB = 3'd3, OP_LBU = 3'd4, OP_SB = 3'd5;
  localparam logic [4:0] EC_MOD = 5'd1, EC_TLBL = 5'd2, EC_TLBS = 5'd3, EC_ADEL = 5'd4, EC_ADES = 5'd5;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [19:0] pfn1;
    logic        d1;
    logic        v1;
    logic [19:0] pfn0;
    logic        d0;
    logic        v0;
  } tlb_entry_t;

  typedef struct packed {
    logic                       en;
    logic [TLB_INDEX_WIDTH-1:0] idx;
    tlb_entry_t                 entry;
  } tlb_wr_t;

  typedef enum logic [1:0] {IDLE, XLATE, BUS} state_t;

  state_t      state, state_nxt;
  tlb_wr_t     tlb_wr;
  tlb_entry_t  tlb [TLB_N];
  logic [2:0]  opt_q;
  logic [31:0] addr_q, wdata_q;

  logic        req_ok, is_load, is_store, is_word, misalign, unmapped;
  logic        hit, pg_v, pg_d;
  logic [19:0] pg_pfn;
  logic        xl_exc;
  logic [4:0]  xl_code;
  logic [31:0] xl_addr, xl_wdata, ld_data;
  logic [3:0]  xl_be;
  logic [7:0]  rd_byte;

  assign tlb_wr   = tlb_write_struct;
  assign req_ok   = (req_opt >= OP_LW) && (req_opt <= OP_SB);
  assign is_load  = (opt_q == OP_LW) || (opt_q == OP_LB) || (opt_q == OP_LBU);
  assign is_store = (opt_q == OP_SW) || (opt_q == OP_SB);
  assign is_word  = (opt_q == OP_LW) || (opt_q == OP_SW);
  assign misalign = is_word && (addr_q[1:0] != 2'b00);
  assign unmapped = (addr_q[31:30] == 2'b10);

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit    = 1'b0;
    pg_v   = 1'b0;
    pg_d   = 1'b0;
    pg_pfn = '0;
    for (int i = TLB_N - 1; i >= 0; i--) begin
      if (tlb[i].vpn2 == addr_q[31:13]) begin
        hit    = 1'b1;
        pg_v   = addr_q[12] ? tlb[i].v1   : tlb[i].v0;
        pg_d   = addr_q[12] ? tlb[i].d1   : tlb[i].d0;
        pg_pfn = addr_q[12] ? tlb[i].pfn1 : tlb[i].pfn0;
      end
    end
  end

  always_comb begin
    xl_exc  = 1'b1;
    xl_code = EC_NONE;
    if (misalign)                      xl_code = is_load ? EC_ADEL : EC_ADES;
    else if (!unmapped && !(hit && pg_v)) xl_code = is_load ? EC_TLBL : EC_TLBS;
    else if (!unmapped && is_store && !pg_d) xl_code = EC_MOD;
    else                               xl_exc  = 1'b0;
  end

  assign xl_addr  = unmapped ? (addr_q & 32'h1FFF_FFFF) : {pg_pfn, addr_q[11:0]};
  assign xl_be    = is_word ? 4'b1111 : (4'b0001 << addr_q[1:0]);
  assign xl_wdata = (opt_q == OP_SB) ? {4{wdata_q[7:0]}} : wdata_q;
  assign rd_byte  = phy_rdata[{addr_q[1:0], 3'b000} +: 8];

  always_comb begin
    ld_data = phy_rdata;
    if (opt_q == OP_LB)       ld_data = {{24{rd_byte[7]}}, rd_byte};
    else if (opt_q == OP_LBU) ld_data = {24'h0, rd_byte};
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_ok)  state_nxt = XLATE;
      XLATE:   state_nxt = xl_exc ? IDLE : BUS;
      BUS:     if (phy_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy          <= 1'b0;
      phy_rd        <= 1'b0;
      phy_wr        <= 1'b0;
      phy_be        <= '0;
      phy_addr      <= '0;
      phy_wdata     <= '0;
      resp_rdata    <= '0;
      resp_exc_code <= EC_NONE;
      opt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: if (req_ok) begin
          opt_q         <= req_opt;
          addr_q        <= req_addr;
          wdata_q       <= req_wdata;
          resp_exc_code <= EC_NONE;
        end
        XLATE: if (xl_exc) begin
          resp_exc_code <= xl_code;
        end else begin
          phy_addr  <= xl_addr;
          phy_be    <= xl_be;
          phy_wdata <= xl_wdata;
          phy_rd    <= is_load;
          phy_wr    <= !is_load;
        end
        BUS: if (phy_ack) begin
          phy_rd <= 1'b0;
          phy_wr <= 1'b0;
          if (is_load) resp_rdata <= ld_data;
        end
        default: ;
      endcase
    end
  end

  // Lookup reads tlb[] combinationally, so a write on the same edge is seen next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TLB_N; i++) tlb[i] <= '0;
    end else if (tlb_wr.en) begin
      tlb[tlb_wr.idx] <= tlb_wr.entry;
    end
  end
endmodule

// File: tb/tb_mmu_data_port.sv
// Randomized bench for mmu_data_port against a spec-level translation model.
module tb_mmu_data_port;
  localparam int         IW      = 3;
  localparam logic [4:0] EC_NONE = 5'h1F;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req_opt;
  logic [31:0]   req_addr, req_wdata;
  logic [IW+63:0] tlb_write_struct;
  logic [31:0]   resp_rdata;
  logic [4:0]    resp_exc_code;
  logic          busy;
  logic [31:0]   phy_addr, phy_wdata, phy_rdata;
  logic [3:0]    phy_be;
  logic          phy_rd, phy_wr, phy_ack;

  mmu_data_port #(.TLB_INDEX_WIDTH(IW), .EC_NONE(EC_NONE)) dut (
    .clk(clk), .rst(rst), .req_opt(req_opt), .req_addr(req_addr), .req_wdata(req_wdata),
    .tlb_write_struct(tlb_write_struct), .resp_rdata(resp_rdata), .resp_exc_code(resp_exc_code),
    .busy(busy), .phy_addr(phy_addr), .phy_wdata(phy_wdata), .phy_be(phy_be),
    .phy_rd(phy_rd), .phy_wr(phy_wr), .phy_rdata(phy_rdata), .phy_ack(phy_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [18:0] m_vpn [8];
  logic [19:0] m_pfn [8][2];
  logic        m_v   [8][2];
  logic        m_d   [8][2];
  logic [31:0] m_rdata;
  logic [4:0]  m_exc;
  logic [18:0] vpn_pool [4] = '{19'h00200, 19'h7FFFF, 19'h00001, 19'h60000};

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_vpn[i] = '0;
      for (int p = 0; p < 2; p++) begin m_pfn[i][p] = '0; m_v[i][p] = 0; m_d[i][p] = 0; end
    end
    m_rdata = '0;
    m_exc   = EC_NONE;
  endfunction

  function automatic logic [IW+63:0] wr_word(input int idx, input logic [18:0] vpn,
      input logic [19:0] p1, input logic d1, v1, input logic [19:0] p0, input logic d0, v0);
    logic [IW-1:0] ix;
    ix = IW'(idx);
    return {1'b1, ix, vpn, p1, d1, v1, p0, d0, v0};
  endfunction

  function automatic void model_write(input logic [IW+63:0] w);
    int idx;
    idx = int'(w[IW+62:63]);
    m_vpn[idx]    = w[62:44];
    m_pfn[idx][1] = w[43:24]; m_d[idx][1] = w[23]; m_v[idx][1] = w[22];
    m_pfn[idx][0] = w[21:2];  m_d[idx][0] = w[1];  m_v[idx][0] = w[0];
  endfunction

  function automatic logic [IW+63:0] rand_wr();
    return wr_word($urandom_range(0, 7), vpn_pool[$urandom_range(0, 3)], 20'($urandom),
                   1'($urandom), 1'($urandom), 20'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  task automatic tlb_write(input logic [IW+63:0] w);
    @(negedge clk);
    tlb_write_struct = w;
    @(negedge clk);
    tlb_write_struct = '0;
    model_write(w);
  endtask

  task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input int nwait, input logic [31:0] brd, input bit side_wr, input bit spur);
    logic [4:0]  e_exc;
    logic [31:0] e_pa, e_wd, e_rd, bv, hold_pa;
    logic [3:0]  e_be;
    logic [IW+63:0] sw;
    bit is_ld, is_st, word, unm, hit, e_bus, seen, done;
    int hi, pg, cnt, cd;

    is_ld = (op == 1) || (op == 3) || (op == 4);
    is_st = (op == 2) || (op == 5);
    word  = (op == 1) || (op == 2);
    unm   = (a >= 32'h8000_0000) && (a < 32'hC000_0000);
    e_exc = EC_NONE;
    e_pa  = a % 32'h2000_0000;
    if (word && (a % 4 != 0)) e_exc = is_ld ? 5'd4 : 5'd5;
    else if (!unm) begin
      hit = 0; hi = 0; pg = int'(a[12]);
      for (int i = 0; i < 8; i++) if (!hit && m_vpn[i] == a[31:13]) begin hit = 1; hi = i; end
      if (!hit || !m_v[hi][pg])      e_exc = is_ld ? 5'd2 : 5'd3;
      else if (is_st && !m_d[hi][pg]) e_exc = 5'd1;
      e_pa = {m_pfn[hi][pg], a[11:0]};
    end
    e_be  = word ? 4'b1111 : 4'(1 << (a % 4));
    e_wd  = (op == 5) ? {4{wd[7:0]}} : wd;
    bv    = (brd >> (8 * (a % 4))) & 32'hFF;
    e_bus = (e_exc == EC_NONE);
    e_rd  = m_rdata;
    if (e_bus && op == 1) e_rd = brd;
    if (e_bus && op == 4) e_rd = bv;
    if (e_bus && op == 3) e_rd = bv[7] ? (bv | 32'hFFFF_FF00) : bv;

    @(negedge clk);
    req_opt = op; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_opt = 3'd0; req_addr = $urandom; req_wdata = $urandom;
    if (!(is_ld || is_st)) begin
      check("idle_ignore_busy", {31'h0, busy}, 32'h0);
      check("idle_ignore_exc", {27'h0, resp_exc_code}, {27'h0, m_exc});
      return;
    end
    check("acc_busy", {31'h0, busy}, 32'h1);
    check("acc_exc", {27'h0, resp_exc_code}, {27'h0, EC_NONE});
    if (spur) req_opt = 3'($urandom_range(1, 5));
    if (side_wr) begin sw = rand_wr(); tlb_write_struct = sw; end
    cnt = 1; seen = 0; done = 0; cd = 0; hold_pa = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      req_opt = 3'd0; phy_ack = 1'b0; tlb_write_struct = '0; phy_rdata = $urandom;
      if (!busy) begin done = 1; break; end
      cnt++;
      if (phy_rd || phy_wr) begin
        if (!seen) begin
          seen = 1; cd = nwait; hold_pa = phy_addr;
          check("bus_addr", phy_addr, e_pa);
          check("bus_be", {28'h0, phy_be}, {28'h0, e_be});
          check("bus_rdwr", {30'h0, phy_rd, phy_wr}, {30'h0, is_ld, is_st});
          if (is_st) check("bus_wdata", phy_wdata, e_wd);
        end else check("bus_hold", phy_addr, hold_pa);
        if (cd == 0) begin phy_ack = 1'b1; phy_rdata = brd; end
        else cd--;
      end
    end
    check("timeout", {31'h0, done}, 32'h1);
    check("busy_cycles", cnt, e_bus ? 32'(2 + nwait) : 32'd1);
    check("bus_seen", {31'h0, seen}, {31'h0, e_bus});
    check("rdwr_drop", {30'h0, phy_rd, phy_wr}, 32'h0);
    check("exc", {27'h0, resp_exc_code}, {27'h0, e_exc});
    check("rdata", resp_rdata, e_rd);
    m_exc = e_exc; m_rdata = e_rd;
    if (side_wr) model_write(sw);
  endtask

  task automatic stray_ack();
    @(negedge clk);
    phy_ack = 1'b1; phy_rdata = $urandom;
    @(negedge clk);
    phy_ack = 1'b0;
    check("stray_busy", {31'h0, busy}, 32'h0);
    check("stray_rdata", resp_rdata, m_rdata);
  endtask

  function automatic logic [31:0] rand_addr(input bit word);
    logic [31:0] a;
    case ($urandom_range(0, 2))
      0:       a = 32'h8000_0000 | (32'($urandom) & 32'h3FFF_FFFF);
      1:       a = {vpn_pool[$urandom_range(0, 3)], 13'($urandom)};
      default: a = $urandom;
    endcase
    if (word && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    logic [2:0] op;
    bit ok;
    rst = 1'b0; req_opt = '0; req_addr = '0; req_wdata = '0;
    tlb_write_struct = '0; phy_rdata = '0; phy_ack = 1'b0;
    model_reset();
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rdwr", {30'h0, phy_rd, phy_wr}, 32'h0);
    check("rst_be", {28'h0, phy_be}, 32'h0);
    check("rst_addr", phy_addr, 32'h0);
    check("rst_wdata", phy_wdata, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_exc", {27'h0, resp_exc_code}, {27'h0, EC_NONE});
    @(negedge clk); rst = 1'b1;

    // directed scenarios
    run_req(3'd1, 32'h8000_0010, 32'h0, 2, 32'hCAFE_1234, 0, 0);
    check("d_lw_rdata", resp_rdata, 32'hCAFE_1234);
    run_req(3'd1, 32'h0040_0000, 32'h0, 0, 32'h0, 0, 0);
    check("d_tlbl", {27'h0, resp_exc_code}, 32'd2);
    tlb_write(wr_word(1, 19'h00200, 20'h0, 0, 0, 20'h00123, 0, 1));
    run_req(3'd2, 32'h0040_0004, 32'h1111_2222, 0, 32'h0, 0, 0);
    check("d_mod", {27'h0, resp_exc_code}, 32'd1);
    run_req(3'd4, 32'h0040_0003, 32'h0, 1, 32'hF000_0000, 0, 0);
    check("d_lbu", resp_rdata, 32'h0000_00F0);
    run_req(3'd3, 32'h8000_0001, 32'h0, 0, 32'h0000_8000, 0, 0);
    check("d_lb", resp_rdata, 32'hFFFF_FF80);
    run_req(3'd5, 32'h8000_0002, 32'h0000_00AB, 3, 32'h0, 0, 0);
    run_req(3'd2, 32'h8000_0002, 32'h0, 0, 32'h0, 0, 1);
    check("d_ades", {27'h0, resp_exc_code}, 32'd5);
    run_req(3'd7, 32'h8000_0000, 32'h0, 0, 32'h0, 0, 0);
    stray_ack();
    // duplicate VPN2: index 1 must win over index 6
    tlb_write(wr_word(6, 19'h00200, 20'h0, 0, 0, 20'h0ABCD, 1, 1));
    run_req(3'd1, 32'h0040_0008, 32'h0, 0, 32'h5555_AAAA, 0, 0);

    // reset in the middle of a bus access
    @(negedge clk);
    req_opt = 3'd1; req_addr = 32'h8000_0040;
    @(negedge clk);
    req_opt = 3'd0;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (phy_rd) begin ok = 1; break; end
    end
    check("abort_rd_seen", {31'h0, ok}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("abort_rd", {31'h0, phy_rd}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    stray_ack();
    check("abort_exc", {27'h0, resp_exc_code}, {27'h0, EC_NONE});

    // randomized traffic
    for (int i = 0; i < 8; i++) tlb_write(rand_wr());
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 5) == 0) tlb_write(rand_wr());
      if ($urandom_range(0, 9) == 0) stray_ack();
      op = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(1, 5));
      run_req(op, rand_addr(op == 1 || op == 2), $urandom, $urandom_range(0, 4), $urandom,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mmu_data_port.md
MMU_DATA_PORT -- requirements
Module: mmu_data_port

Interface
REQ-001 The block SHALL have parameter TLB_INDEX_WIDTH, default 3, giving the log2 of the TLB entry count (8 entries).
REQ-002 The block SHALL have parameter EC_NONE, default 5'h1F, the "no exception" code.
REQ-003 The block SHALL have ports as follows, and SHALL use one clock with an asynchronous, active-low reset:
- clk, input, 1: single clock; all state updates on the posedge.
- rst, input, 1: asynchronous, active-low reset.
- req_opt, input, 3: operation code; 0 NONE, 1 LW, 2 SW, 3 LB, 4 LBU, 5 SB, others treated as NONE.
- req_addr, input, 32: virtual address.
- req_wdata, input, 32: store data.
- tlb_write_struct, input, 1+TLB_INDEX_WIDTH+63: {enable, index, entry}.
- The 63-bit entry is {VPN2[18:0], PFN1[19:0], D1, V1, PFN0[19:0], D0, V0}.
- resp_rdata, output, 32: load result.
- resp_exc_code, output, 5: exception code; 1 MOD, 2 TLBL, 3 TLBS, 4 ADEL, 5 ADES, EC_NONE otherwise.
- busy, output, 1: request in progress.
- phy_addr, output, 32: physical byte address.
- phy_wdata, output, 32: physical write data.
- phy_be, output, 4: byte enables.
- phy_rd, output, 1: read request.
- phy_wr, output, 1: write request.
- phy_rdata, input, 32: read data, valid with phy_ack.
- phy_ack, input, 1: one-cycle completion pulse.

Function
REQ-004 The block SHALL implement three states: IDLE, XLATE and BUS; busy SHALL be registered and high exactly when the state is not IDLE.
REQ-005 In IDLE, a req_opt other than NONE sampled on a posedge SHALL:
- latch opt, addr and wdata;
- clear resp_exc_code to EC_NONE;
- set busy on that same edge;
- go to XLATE.
REQ-006 A req_opt sampled while busy SHALL be ignored; the requester holds req_opt for at most one cycle.
REQ-007 In XLATE (one cycle), an LW or SW with addr[1:0] != 0 SHALL raise ADEL or ADES respectively.
REQ-008 Addresses 0x80000000-0xBFFFFFFF SHALL be unmapped: phy_addr = addr & 0x1FFFFFFF.
REQ-009 All other addresses SHALL be mapped, as follows:
- Match VPN2 == addr[31:13] against all entries.
- On multiple matches, the lowest index wins.
- Select PFN1/D1/V1 if addr[12]=1, else PFN0/D0/V0.
- phy_addr = {PFN, addr[11:0]}.
REQ-010 A TLB miss, or V=0, SHALL raise TLBL for loads and TLBS for stores; a store with V=1 and D=0 SHALL raise MOD.
REQ-011 Exception priority SHALL be: alignment, then TLB miss/invalid, then MOD.
REQ-012 On an exception in XLATE, the block SHALL set resp_exc_code, clear busy, return to IDLE, and issue no phy_rd or phy_wr.
REQ-013 On no exception, XLATE SHALL assert phy_rd (loads) or phy_wr (stores) together with phy_addr, phy_wdata and phy_be, then go to BUS.
REQ-014 phy_be SHALL be 4'b1111 for LW and SW; for LB, LBU and SB it SHALL be the single bit 1<<addr[1:0].
REQ-015 For SB, phy_wdata SHALL be the low byte replicated four times.
REQ-016 In BUS, the request signals SHALL be held stable until phy_ack.
REQ-017 On the phy_ack edge in BUS, the block SHALL:
- drop phy_rd and phy_wr;
- load resp_rdata;
- clear busy;
- return to IDLE.
REQ-018 resp_rdata SHALL be formed little-endian:
- LW: phy_rdata.
- LB: byte addr[1:0], sign-extended.
- LBU: byte addr[1:0], zero-extended.
- SW and SB: resp_rdata unchanged.
REQ-019 resp_exc_code and resp_rdata SHALL hold their values until the next accepted request.
REQ-020 Latency SHALL be:
- Exception: busy high for 1 cycle.
- Bus access: busy high for 2 + N cycles, where N is the number of cycles from the phy_rd/phy_wr assertion edge to phy_ack.
REQ-021 When tlb_write_struct.enable is high on a posedge, the block SHALL write entry to the given index.
REQ-022 A lookup in the same cycle as a TLB write SHALL use the pre-write contents.
REQ-023 A TLB write SHALL be accepted in any state.
REQ-024 phy_ack received outside BUS SHALL be ignored.

Reset
REQ-025 While rst=0, asynchronously:
- state SHALL be IDLE;
- busy, phy_rd and phy_wr SHALL be 0;
- phy_be SHALL be 0;
- phy_addr, phy_wdata and resp_rdata SHALL be 0;
- resp_exc_code SHALL be EC_NONE;
- all TLB entries SHALL be 0, so every mapped access raises TLBL or TLBS.
REQ-026 Reset asserted in XLATE or BUS SHALL abort the access immediately; a later phy_ack SHALL be ignored.

Verification
REQ-027 LW 0x80000010, phy_ack 2 cycles after phy_rd -> phy_addr=0x00000010, be=4'b1111, resp_rdata=phy_rdata, busy high 4 cycles, exc=EC_NONE.
REQ-028 After reset, LW 0x00400000 -> resp_exc_code=2 (TLBL), busy high 1 cycle, phy_rd never asserted.
REQ-029 Write index 1 = {VPN2=0x00200, PFN0=0x00123, D0=0, V0=1}, then SW 0x00400004 -> MOD (1); LBU 0x00400003 with phy_rdata=0xF0000000 -> phy_addr=0x00123003, be=4'b1000, resp_rdata=0x000000F0.
REQ-030 LB 0x80000001 with phy_rdata=0x00008000 -> resp_rdata=0xFFFFFF80; SB 0x80000002 with wdata=0x000000AB -> phy_wdata=0xABABABAB, be=4'b0100.
REQ-031 SW 0x80000002 -> ADES (5), no bus cycle; a second req_opt pulse while busy is ignored.
REQ-032 Reset asserted while in BUS waiting for phy_ack -> phy_rd and busy drop immediately; a later phy_ack causes no state change.
